kara_pipe_mult: RTL and testbench

Parametrised, fully pipelined unsigned Karatsuba multiplier with valid/ready handshakes and a tag sideband. Successor to the fixed 18-bit Karatsuba unit: it supports any even operand width W and propagates backpressure. It sits in the modular-multiplier datapath and feeds partial products to the Montgomery reduction stage. Throughput is one product per cycle.

---
 rtl/kara_pipe_mult.sv | 82 ++++++++
 tb/tb_kara_pipe_mult.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/kara_pipe_mult.sv
// kara_pipe_mult: three-stage pipelined unsigned Karatsuba multiplier with valid/ready handshakes and tag sideband
module kara_pipe_mult #(
  parameter int W    = 18,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_p,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);
  localparam int H = W / 2;
  logic            adv;
  logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [H-1:0]    a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
  logic [H:0]      sa_q, sa_d, sb_q, sb_d;
  logic [TAGW-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
  logic [W-1:0]    p0_q, p0_d, p2_q, p2_d;
  logic [W+1:0]    pm_q, pm_d, p1;
  logic [2*W-1:0]  p_q, p_d, sum;
  // next state: every stage loads on a global advance and holds otherwise
  always_comb begin
    adv  = !v3_q || out_ready;
    v1_d = adv ? in_valid : v1_q;
    v2_d = adv ? v1_q : v2_q;
    v3_d = adv ? v2_q : v3_q;
    a0_d = adv ? a[H-1:0] : a0_q;
    a1_d = adv ? a[W-1:H] : a1_q;
    b0_d = adv ? b[H-1:0] : b0_q;
    b1_d = adv ? b[W-1:H] : b1_q;
    sa_d = adv ? {1'b0, a[H-1:0]} + {1'b0, a[W-1:H]} : sa_q;
    sb_d = adv ? {1'b0, b[H-1:0]} + {1'b0, b[W-1:H]} : sb_q;
    t1_d = adv ? in_tag : t1_q;
    p0_d = adv ? {{H{1'b0}}, a0_q} * {{H{1'b0}}, b0_q} : p0_q;
    p2_d = adv ? {{H{1'b0}}, a1_q} * {{H{1'b0}}, b1_q} : p2_q;
    pm_d = adv ? {{(H+1){1'b0}}, sa_q} * {{(H+1){1'b0}}, sb_q} : pm_q;
    t2_d = adv ? t1_q : t2_q;
    p1   = pm_q - {2'b00, p0_q} - {2'b00, p2_q};
    sum  = {{W{1'b0}}, p0_q} + ({{(W-2){1'b0}}, p1} << H) + ({{W{1'b0}}, p2_q} << W);
    p_d  = adv ? sum : p_q;
    t3_d = adv ? t2_q : t3_q;
  end
  // pipeline registers; reset clears valids and the visible result only
  always_ff @(posedge clk) begin
    a0_q <= a0_d;
    a1_q <= a1_d;
    b0_q <= b0_d;
    b1_q <= b1_d;
    sa_q <= sa_d;
    sb_q <= sb_d;
    t1_q <= t1_d;
    p0_q <= p0_d;
    p2_q <= p2_d;
    pm_q <= pm_d;
    t2_q <= t2_d;
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      p_q  <= '0;
      t3_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      p_q  <= p_d;
      t3_q <= t3_d;
    end
  end
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out_p     = p_q;
  assign out_tag   = t3_q;
  assign busy      = v1_q | v2_q | v3_q;
endmodule

// File: tb/tb_kara_pipe_mult.sv
// tb_kara_pipe_mult: directed and streaming checks of kara_pipe_mult at W=18, 4 and 64
module tb_kara_pipe_mult;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv, ir, ov, ordy, bsy;
  logic [17:0] a, b;
  logic [3:0]  it, ot;
  logic [35:0] p;

  logic        iv4, ir4, ov4, ordy4, bsy4;
  logic [3:0]  a4, b4, it4, ot4;
  logic [7:0]  p4;

  logic         iv64, ir64, ov64, ordy64, bsy64;
  logic [63:0]  a64, b64;
  logic [3:0]   it64, ot64;
  logic [127:0] p64;

  int checks = 0;
  int fails  = 0;

  kara_pipe_mult #(.W(18), .TAGW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .in_tag(it),
    .out_valid(ov), .out_ready(ordy), .out_p(p), .out_tag(ot), .busy(bsy));

  kara_pipe_mult #(.W(4), .TAGW(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .in_tag(it4),
    .out_valid(ov4), .out_ready(ordy4), .out_p(p4), .out_tag(ot4), .busy(bsy4));

  kara_pipe_mult #(.W(64), .TAGW(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64), .in_tag(it64),
    .out_valid(ov64), .out_ready(ordy64), .out_p(p64), .out_tag(ot64), .busy(bsy64));

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (ov !== 1'b0) begin fails++; $display("FAIL reset_out_valid[%0d] got %b exp 0", k, ov); end
      checks++; if (p !== 36'd0) begin fails++; $display("FAIL reset_out_p[%0d] got %h exp 0", k, p); end
      checks++; if (ot !== 4'd0) begin fails++; $display("FAIL reset_out_tag[%0d] got %h exp 0", k, ot); end
      checks++; if (bsy !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d] got %b exp 0", k, bsy); end
      checks++; if (ir !== 1'b1) begin fails++; $display("FAIL reset_in_ready[%0d] got %b exp 1", k, ir); end
      rst = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single();
    ordy = 1'b1; iv = 1'b1; a = 18'd12345; b = 18'd6789; it = 4'h5;
    @(posedge clk); #1;
    iv = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (ov !== (k == 3)) begin fails++; $display("FAIL single_valid[%0d] got %b exp %b", k, ov, k == 3); end
      if (k == 3) begin
        checks++; if (p !== 36'd83810205) begin fails++; $display("FAIL single_p got %0d exp 83810205", p); end
        checks++; if (ot !== 4'h5) begin fails++; $display("FAIL single_tag got %h exp 5", ot); end
      end
      @(posedge clk); #1;
    end
  endtask

  logic [17:0] ca [3] = '{18'h3FFFF, 18'h3FFFF, 18'h20000};
  logic [17:0] cb [3] = '{18'h3FFFF, 18'h00000, 18'h20000};
  logic [35:0] ce [3] = '{36'hFFFF80001, 36'h0, 36'h400000000};

  task automatic test_corners();
    ordy = 1'b1;
    for (int c = 0; c < 7; c++) begin
      checks++; if (ov !== (c >= 3 && c < 6)) begin fails++; $display("FAIL corner_valid[%0d] got %b", c, ov); end
      if (c >= 3 && c < 6) begin
        checks++; if (p !== ce[c-3]) begin fails++; $display("FAIL corner_p[%0d] got %h exp %h", c - 3, p, ce[c-3]); end
        checks++; if (ot !== 4'(c + 3)) begin fails++; $display("FAIL corner_tag[%0d] got %h exp %h", c - 3, ot, 4'(c + 3)); end
      end
      if (c < 3) begin iv = 1'b1; a = ca[c]; b = cb[c]; it = 4'(c + 6); end else iv = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bubbles();
    logic [4:0] pv = 5'b01101;
    logic       e;
    ordy = 1'b1;
    for (int c = 0; c < 9; c++) begin
      e = (c >= 3 && c < 8) ? pv[c-3] : 1'b0;
      checks++; if (ov !== e) begin fails++; $display("FAIL bubble_valid[%0d] got %b exp %b", c, ov, e); end
      if (e) begin
        checks++; if (p !== 36'((c - 2) * (c - 1))) begin fails++; $display("FAIL bubble_p[%0d] got %0d exp %0d", c, p, (c - 2) * (c - 1)); end
      end
      if (c < 5) begin iv = pv[c]; a = 18'(c + 1); b = 18'(c + 2); it = 4'(c); end else iv = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] qp[$];
    logic [3:0]  qt[$];
    logic [35:0] ep;
    logic [3:0]  et;
    ordy = 1'b1;
    for (int c = 0; c < 104; c++) begin
      checks++; if (ov !== (c >= 3 && c < 103)) begin fails++; $display("FAIL stream18_valid[%0d] got %b", c, ov); end
      if (ov && qp.size() > 0) begin
        ep = qp.pop_front(); et = qt.pop_front();
        checks++; if (p !== ep || ot !== et) begin fails++; $display("FAIL stream18_p[%0d] got %h/%h exp %h/%h", c, p, ot, ep, et); end
      end
      if (c < 100) begin
        iv = 1'b1; a = 18'($urandom); b = 18'($urandom); it = c[3:0];
        qp.push_back({18'd0, a} * {18'd0, b}); qt.push_back(it);
      end else iv = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  logic [17:0] ba [3] = '{18'd3, 18'd1000, 18'h3FFFF};
  logic [17:0] bb [3] = '{18'd5, 18'd1000, 18'd2};
  logic [35:0] be [3] = '{36'd15, 36'd1000000, 36'h7FFFE};

  task automatic test_backpressure();
    ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (ir !== 1'b1) begin fails++; $display("FAIL bp_fill_ready[%0d] got %b exp 1", k, ir); end
      iv = 1'b1; a = ba[k]; b = bb[k]; it = 4'(k + 1);
      @(posedge clk); #1;
    end
    iv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++; if (ir !== 1'b0) begin fails++; $display("FAIL bp_hold_ready[%0d] got %b exp 0", k, ir); end
      checks++; if (ov !== 1'b1 || p !== 36'd15 || ot !== 4'd1) begin fails++; $display("FAIL bp_hold_out[%0d] got %b/%0d/%h exp 1/15/1", k, ov, p, ot); end
      checks++; if (bsy !== 1'b1) begin fails++; $display("FAIL bp_hold_busy[%0d] got %b exp 1", k, bsy); end
      @(posedge clk); #1;
    end
    ordy = 1'b1; #1;
    checks++; if (ir !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b exp 1", ir); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (ov !== (k < 3)) begin fails++; $display("FAIL bp_drain_valid[%0d] got %b", k, ov); end
      if (k < 3) begin
        checks++; if (p !== be[k] || ot !== 4'(k + 1)) begin fails++; $display("FAIL bp_drain_p[%0d] got %0d/%h exp %0d/%h", k, p, ot, be[k], k + 1); end
      end
      @(posedge clk); #1;
    end
    checks++; if (bsy !== 1'b0) begin fails++; $display("FAIL bp_end_busy got %b exp 0", bsy); end
  endtask

  task automatic test_reset_midstream();
    ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv = 1'b1; a = 18'(k + 100); b = 18'(k + 7); it = 4'(k + 9);
      @(posedge clk); #1;
    end
    iv = 1'b0;
    checks++; if (ov !== 1'b1) begin fails++; $display("FAIL mid_pre_valid got %b exp 1", ov); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (ov !== 1'b0 || p !== 36'd0 || ot !== 4'd0) begin fails++; $display("FAIL mid_rst_out got %b/%h/%h exp 0/0/0", ov, p, ot); end
    checks++; if (bsy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy got %b exp 0", bsy); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (ov !== 1'b0) begin fails++; $display("FAIL mid_stale[%0d] got %b exp 0", k, ov); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_exhaustive_w4();
    logic [7:0] qp[$];
    logic [3:0] qt[$];
    logic [7:0] ep;
    logic [3:0] et;
    ordy4 = 1'b1;
    for (int c = 0; c < 260; c++) begin
      checks++; if (ov4 !== (c >= 3 && c < 259)) begin fails++; $display("FAIL w4_valid[%0d] got %b", c, ov4); end
      if (ov4 && qp.size() > 0) begin
        ep = qp.pop_front(); et = qt.pop_front();
        checks++; if (p4 !== ep || ot4 !== et) begin fails++; $display("FAIL w4_p[%0d] got %h/%h exp %h/%h", c, p4, ot4, ep, et); end
      end
      if (c < 256) begin
        iv4 = 1'b1; a4 = c[7:4]; b4 = c[3:0]; it4 = c[3:0];
        qp.push_back({4'd0, a4} * {4'd0, b4}); qt.push_back(it4);
      end else iv4 = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random_w64();
    logic [127:0] qp[$];
    logic [3:0]   qt[$];
    logic [127:0] ep;
    logic [3:0]   et;
    ordy64 = 1'b1;
    for (int c = 0; c < 104; c++) begin
      checks++; if (ov64 !== (c >= 3 && c < 103)) begin fails++; $display("FAIL w64_valid[%0d] got %b", c, ov64); end
      if (ov64 && qp.size() > 0) begin
        ep = qp.pop_front(); et = qt.pop_front();
        checks++; if (p64 !== ep || ot64 !== et) begin fails++; $display("FAIL w64_p[%0d] got %h exp %h", c, p64, ep); end
      end
      if (c < 100) begin
        iv64 = 1'b1; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; it64 = c[3:0];
        if (c == 0) begin a64 = '1; b64 = '1; end
        qp.push_back({64'd0, a64} * {64'd0, b64}); qt.push_back(it64);
      end else iv64 = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    iv = 1'b0; a = '0; b = '0; it = '0; ordy = 1'b1;
    iv4 = 1'b0; a4 = '0; b4 = '0; it4 = '0; ordy4 = 1'b1;
    iv64 = 1'b0; a64 = '0; b64 = '0; it64 = '0; ordy64 = 1'b1;
    test_reset();
    test_single();
    test_corners();
    test_bubbles();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_exhaustive_w4();
    test_random_w64();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
